soml_hq_dh_seq: RTL and testbench

//  Frame-level sequencer for the Hq/D_h compute core (Hq_Dh_cal) in the SOML decoder.
//  On start: streams H-coefficient addresses to the H memory, then kicks the core once per
//  q-index. Collects each D_h result and hands it downstream over valid/ready.
//  A watchdog bounds every core run. Sits between the decoder top FSM and the Hq_Dh_cal core.

---
 rtl/soml_pkg.sv | 25 ++
 rtl/soml_wdt.sv | 45 ++++
 rtl/soml_hq_dh_seq.sv | 194 +++++++++++++++++++
 tb/tb_soml_hq_dh_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/soml_pkg.sv
// Shared definitions for the SOML decoder sequencing stages.
// Contents:
//   DwDef, NqDef    default D_h width and q-indices per frame
//   seq_state_e     frame sequencer state encoding (3 bits)
//   cnt_width()     counter width for a given terminal count, never below 1
package soml_pkg;

    localparam int unsigned DwDef = 16;
    localparam int unsigned NqDef = 4;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StKick = 3'd2,
        StWait = 3'd3,
        StOut  = 3'd4,
        StDone = 3'd5
    } seq_state_e;

    // Width needed to hold 0..n-1, at least one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/soml_wdt.sv
// Watchdog counter: synchronous clear, count enable, terminal flag at Tmo-1.
// The count holds at the terminal value rather than wrapping.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous reset, active-high
//   clr_i    clear count to zero (wins over en_i)
//   en_i     advance count by one
//   term_o   count has reached Tmo-1
module soml_wdt
    import soml_pkg::*;
#(
    parameter int unsigned Tmo = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    localparam int unsigned CntW = cnt_width(Tmo);
    localparam logic [CntW-1:0] TermVal = CntW'(Tmo - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign term_o = (cnt_q == TermVal);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !term_o) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/soml_hq_dh_seq.sv
// Frame sequencer for the Hq/D_h compute core. On start it streams Nh H-memory
// addresses, then kicks the core once per q-index, captures each D_h result and
// offers it downstream over valid/ready. A watchdog bounds every core run; on
// expiry the frame is aborted with a sticky error.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             frame start, honoured only when idle
//   busy_o              high whenever not idle
//   h_rd_o, h_addr_o    H memory read strobe and address
//   dh_start_o, dh_q_o  one-cycle core kick and the q-index for that run
//   core_done_i         core completion, honoured only while waiting
//   core_dh_i           core result, valid with core_done_i
//   dh_valid_o, dh_ready_i, dh_data_o, dh_idx_o   result handshake
//   frame_done_o        one-cycle pulse at end of frame (normal or aborted)
//   err_timeout_o       sticky watchdog error, cleared by accepted start or reset
// All outputs come straight from registers.
module soml_hq_dh_seq
    import soml_pkg::*;
#(
    parameter int unsigned Dw  = DwDef,
    parameter int unsigned Nq  = NqDef,
    parameter int unsigned Qw  = 2,
    parameter int unsigned Nh  = 16,
    parameter int unsigned Aw  = 4,
    parameter int unsigned Tmo = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    output logic          busy_o,
    output logic          h_rd_o,
    output logic [Aw-1:0] h_addr_o,
    output logic          dh_start_o,
    output logic [Qw-1:0] dh_q_o,
    input  logic          core_done_i,
    input  logic [Dw-1:0] core_dh_i,
    output logic          dh_valid_o,
    input  logic          dh_ready_i,
    output logic [Dw-1:0] dh_data_o,
    output logic [Qw-1:0] dh_idx_o,
    output logic          frame_done_o,
    output logic          err_timeout_o
);

    localparam logic [Qw-1:0] QLast = Qw'(Nq - 1);
    localparam logic [Aw-1:0] ALast = Aw'(Nh - 1);

    seq_state_e    state_q, state_d;
    logic [Qw-1:0] q_q, q_d;
    logic          busy_q, busy_d;
    logic          h_rd_q, h_rd_d;
    logic [Aw-1:0] h_addr_q, h_addr_d;
    logic          dh_start_q, dh_start_d;
    logic [Qw-1:0] dh_q_q, dh_q_d;
    logic          dh_valid_q, dh_valid_d;
    logic [Dw-1:0] dh_data_q, dh_data_d;
    logic [Qw-1:0] dh_idx_q, dh_idx_d;
    logic          frame_done_q, frame_done_d;
    logic          err_q, err_d;

    logic wdt_term;

    // Counter is cleared while kicking so every core run starts from zero.
    soml_wdt #(
        .Tmo(Tmo)
    ) u_wdt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (state_q == StKick),
        .en_i  (state_q == StWait),
        .term_o(wdt_term)
    );

    always_comb begin
        state_d      = state_q;
        q_d          = q_q;
        h_rd_d       = h_rd_q;
        h_addr_d     = h_addr_q;
        dh_start_d   = 1'b0;
        dh_q_d       = dh_q_q;
        dh_valid_d   = dh_valid_q;
        dh_data_d    = dh_data_q;
        dh_idx_d     = dh_idx_q;
        frame_done_d = 1'b0;
        err_d        = err_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d  = StLoad;
                    err_d    = 1'b0;
                    q_d      = '0;
                    h_addr_d = '0;
                end
            end
            StLoad: begin
                // First LOAD cycle raises the strobe at address 0; the h_addr register
                // itself is the address counter and stops at Nh-1.
                if (!h_rd_q) begin
                    h_rd_d   = 1'b1;
                    h_addr_d = '0;
                end else if (h_addr_q == ALast) begin
                    h_rd_d     = 1'b0;
                    h_addr_d   = '0;
                    state_d    = StKick;
                    dh_start_d = 1'b1;
                    dh_q_d     = q_q;
                end else begin
                    h_addr_d = h_addr_q + Aw'(1);
                end
            end
            StKick: begin
                state_d = StWait;
            end
            StWait: begin
                // core_done takes priority over a watchdog expiry in the same cycle.
                if (core_done_i) begin
                    dh_data_d  = core_dh_i;
                    dh_idx_d   = q_q;
                    dh_valid_d = 1'b1;
                    state_d    = StOut;
                end else if (wdt_term) begin
                    err_d        = 1'b1;
                    frame_done_d = 1'b1;
                    state_d      = StDone;
                end
            end
            StOut: begin
                if (dh_ready_i) begin
                    dh_valid_d = 1'b0;
                    if (q_q == QLast) begin
                        frame_done_d = 1'b1;
                        state_d      = StDone;
                    end else begin
                        q_d        = q_q + Qw'(1);
                        dh_start_d = 1'b1;
                        dh_q_d     = q_q + Qw'(1);
                        state_d    = StKick;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            q_q          <= '0;
            busy_q       <= 1'b0;
            h_rd_q       <= 1'b0;
            h_addr_q     <= '0;
            dh_start_q   <= 1'b0;
            dh_q_q       <= '0;
            dh_valid_q   <= 1'b0;
            dh_data_q    <= '0;
            dh_idx_q     <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            q_q          <= q_d;
            busy_q       <= busy_d;
            h_rd_q       <= h_rd_d;
            h_addr_q     <= h_addr_d;
            dh_start_q   <= dh_start_d;
            dh_q_q       <= dh_q_d;
            dh_valid_q   <= dh_valid_d;
            dh_data_q    <= dh_data_d;
            dh_idx_q     <= dh_idx_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign busy_o        = busy_q;
    assign h_rd_o        = h_rd_q;
    assign h_addr_o      = h_addr_q;
    assign dh_start_o    = dh_start_q;
    assign dh_q_o        = dh_q_q;
    assign dh_valid_o    = dh_valid_q;
    assign dh_data_o     = dh_data_q;
    assign dh_idx_o      = dh_idx_q;
    assign frame_done_o  = frame_done_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_soml_hq_dh_seq.sv
module tb_soml_hq_dh_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        h_rd;
    logic [3:0]  h_addr;
    logic        dh_start;
    logic [1:0]  dh_q;
    logic        core_done;
    logic [15:0] core_dh;
    logic        dh_valid;
    logic        dh_ready;
    logic [15:0] dh_data;
    logic [1:0]  dh_idx;
    logic        frame_done;
    logic        err_timeout;

    int n_assert = 0;
    int n_fail   = 0;

    soml_hq_dh_seq u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .busy_o       (busy),
        .h_rd_o       (h_rd),
        .h_addr_o     (h_addr),
        .dh_start_o   (dh_start),
        .dh_q_o       (dh_q),
        .core_done_i  (core_done),
        .core_dh_i    (core_dh),
        .dh_valid_o   (dh_valid),
        .dh_ready_i   (dh_ready),
        .dh_data_o    (dh_data),
        .dh_idx_o     (dh_idx),
        .frame_done_o (frame_done),
        .err_timeout_o(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: done one cycle after the kick, result 0x0100 + q; hang_q never answers.
    int   hang_q = -1;
    logic auto_done = 1'b0;
    logic force_done;
    always @(posedge clk) auto_done <= dh_start && (int'(dh_q) != hang_q);
    assign core_done = auto_done | force_done;
    assign core_dh   = 16'h0100 + {14'd0, dh_q};

    // Monitor: H read sequence, delivered results, valid length, stall stability.
    logic        mon_clr;
    int          hrd_cnt, addr_err, unstable, vrun;
    logic [3:0]  exp_addr;
    logic        prev_stall;
    logic [17:0] prev_data;
    logic [17:0] res_q[$];
    int          vlen_q[$];

    always @(posedge clk) begin
        if (mon_clr) begin
            hrd_cnt    <= 0;
            addr_err   <= 0;
            exp_addr   <= 4'd0;
            unstable   <= 0;
            vrun       <= 0;
            prev_stall <= 1'b0;
            res_q.delete();
            vlen_q.delete();
        end else begin
            if (h_rd) begin
                if (h_addr != exp_addr) addr_err <= addr_err + 1;
                exp_addr <= exp_addr + 4'd1;
                hrd_cnt  <= hrd_cnt + 1;
            end
            if (dh_valid && dh_ready) begin
                res_q.push_back({dh_idx, dh_data});
                vlen_q.push_back(vrun + 1);
                vrun <= 0;
            end else if (dh_valid) begin
                vrun <= vrun + 1;
            end
            if (prev_stall && ({dh_idx, dh_data} != prev_data)) unstable <= unstable + 1;
            prev_stall <= dh_valid && !dh_ready;
            prev_data  <= {dh_idx, dh_data};
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string t);
        chk({t, "_busy"}, {31'd0, busy}, 32'd0);
        chk({t, "_hrd"}, {31'd0, h_rd}, 32'd0);
        chk({t, "_haddr"}, {28'd0, h_addr}, 32'd0);
        chk({t, "_dhstart"}, {31'd0, dh_start}, 32'd0);
        chk({t, "_dhq"}, {30'd0, dh_q}, 32'd0);
        chk({t, "_valid"}, {31'd0, dh_valid}, 32'd0);
        chk({t, "_data"}, {16'd0, dh_data}, 32'd0);
        chk({t, "_idx"}, {30'd0, dh_idx}, 32'd0);
        chk({t, "_fdone"}, {31'd0, frame_done}, 32'd0);
        chk({t, "_err"}, {31'd0, err_timeout}, 32'd0);
    endtask

    task automatic chk_res(input string t, input int n);
        chk({t, "_nres"}, res_q.size(), n);
        for (int i = 0; i < n && i < res_q.size(); i++) begin
            chk({t, "_idx"}, {14'd0, res_q[i][17:16]}, i);
            chk({t, "_data"}, {16'd0, res_q[i][15:0]}, 32'h0100 + i);
        end
    endtask

    // Start a frame (start sampled at edge 0) and step until frame_done or limit.
    // Event edges are reported relative to edge 0; -1 means not seen.
    task automatic run_frame(input int spur_start_k, input int spur_done_k, input int rl_from,
                             input int rl_len, input int rst_k, input int limit,
                             output int fd, output int first_kick, output int kick2,
                             output logic err0);
        int nk;
        fd = -1;
        first_kick = -1;
        kick2 = -1;
        nk = 0;
        mon_clr = 1'b1;
        start = 1'b1;
        tick;
        mon_clr = 1'b0;
        start = 1'b0;
        err0 = err_timeout;
        for (int k = 1; k <= limit; k++) begin
            tick;
            if (dh_start) begin
                if (nk == 0) first_kick = k;
                if (nk == 2) kick2 = k;
                nk++;
            end
            if (frame_done && fd < 0) fd = k;
            start      = (k == spur_start_k);
            force_done = (k == spur_done_k);
            dh_ready   = !(k >= rl_from && k < rl_from + rl_len);
            rst        = (k == rst_k);
            if (fd >= 0) break;
        end
        start = 1'b0;
        force_done = 1'b0;
        dh_ready = 1'b1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int   fd, k0, k2;
    logic e0;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        dh_ready = 1'b1;
        force_done = 1'b0;
        mon_clr = 1'b1;
        repeat (3) tick;
        chk_idle("reset");
        rst = 1'b0;
        mon_clr = 1'b0;
        tick;

        // 1: nominal frame
        run_frame(-1, -1, -1, 0, -1, 200, fd, k0, k2, e0);
        chk("t1_fdone_edge", fd, 29);
        chk("t1_first_kick", k0, 17);
        chk("t1_hrd_cnt", hrd_cnt, 16);
        chk("t1_addr_err", addr_err, 0);
        chk_res("t1", 4);
        chk("t1_err", {31'd0, err_timeout}, 32'd0);
        tick;
        chk("t1_fdone_pulse", {31'd0, frame_done}, 32'd0);
        chk("t1_busy_drop", {31'd0, busy}, 32'd0);

        // 5: spurious start in WAIT, spurious core_done in LOAD
        run_frame(18, 8, -1, 0, -1, 200, fd, k0, k2, e0);
        chk("t5_fdone_edge", fd, 29);
        chk("t5_first_kick", k0, 17);
        chk("t5_hrd_cnt", hrd_cnt, 16);
        chk("t5_addr_err", addr_err, 0);
        chk_res("t5", 4);
        tick;
        chk("t5_busy_drop", {31'd0, busy}, 32'd0);

        // 2: backpressure on q=1 for 5 cycles
        run_frame(-1, -1, 22, 5, -1, 200, fd, k0, k2, e0);
        chk("t2_fdone_edge", fd, 34);
        chk("t2_kick_q2", k2, 28);
        chk_res("t2", 4);
        chk("t2_vlen_q1", (vlen_q.size() > 1) ? vlen_q[1] : -1, 6);
        chk("t2_vlen_q0", (vlen_q.size() > 0) ? vlen_q[0] : -1, 1);
        chk("t2_stable", unstable, 0);
        tick;

        // 3: core hangs on q=2
        hang_q = 2;
        run_frame(-1, -1, -1, 0, -1, 200, fd, k0, k2, e0);
        chk("t3_fdone_edge", fd, 88);
        chk("t3_err_set", {31'd0, err_timeout}, 32'd1);
        chk_res("t3", 2);
        tick;
        chk("t3_busy_drop", {31'd0, busy}, 32'd0);
        chk("t3_err_sticky", {31'd0, err_timeout}, 32'd1);

        // 4: core_done exactly in the watchdog terminal cycle of q=2
        run_frame(-1, 87, -1, 0, -1, 200, fd, k0, k2, e0);
        chk("t4_err_cleared_by_start", {31'd0, e0}, 32'd0);
        chk("t4_fdone_edge", fd, 92);
        chk_res("t4", 4);
        chk("t4_err", {31'd0, err_timeout}, 32'd0);
        hang_q = -1;
        tick;

        // 6: reset during WAIT of q=1, then a clean frame
        run_frame(-1, -1, -1, 0, 21, 22, fd, k0, k2, e0);
        chk("t6_no_fdone", fd, -1);
        chk_idle("t6_after_rst");
        tick;
        chk("t6_stay_idle", {31'd0, busy}, 32'd0);
        run_frame(-1, -1, -1, 0, -1, 200, fd, k0, k2, e0);
        chk("t6_fdone_edge", fd, 29);
        chk("t6_hrd_cnt", hrd_cnt, 16);
        chk_res("t6", 4);
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
